// File: rtl/md_sequencer_pkg.sv
// Shared MD definitions: operation codes driven by the E-stage controller,
// FSM state encodings and small elaboration-time helpers.
`timescale 1ns/1ps
package md_sequencer_pkg;

   typedef enum logic [2:0] {
      MD_OP_NONE  = 3'd0,
      MD_OP_MULT  = 3'd1,
      MD_OP_MULTU = 3'd2,
      MD_OP_DIV   = 3'd3,
      MD_OP_DIVU  = 3'd4,
      MD_OP_MTHI  = 3'd5,
      MD_OP_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [1:0] {
      MD_ST_IDLE = 2'd0,
      MD_ST_MUL  = 2'd1,
      MD_ST_DIV  = 2'd2
   } md_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // A latency of 1 still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
             (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
   endfunction

   function automatic logic is_md_op(input logic [2:0] op);
      return (op != MD_OP_NONE) && (op <= MD_OP_MTLO);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: (op, rs, rt) -> {hi, lo}.
// Owns the divide-by-zero and signed-overflow result rules.
`timescale 1ns/1ps
module md_arith
   import md_sequencer_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic        div_zero;
   logic        div_ovf;
   logic [31:0] rt_safe_s;
   logic [31:0] rt_safe_u;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [31:0] quo_u;
   logic [31:0] rem_u;

   assign div_zero = (rt_i == 32'd0);
   assign div_ovf  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

   // Divisors are forced to 1 on the special cases so the dividers never see
   // a zero or overflowing operand; the result mux below supplies the answer.
   assign rt_safe_s = (div_zero || div_ovf) ? 32'd1 : rt_i;
   assign rt_safe_u = div_zero ? 32'd1 : rt_i;

   assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
   assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};
   assign quo_s  = $signed(rs_i) / $signed(rt_safe_s);
   assign rem_s  = $signed(rs_i) % $signed(rt_safe_s);
   assign quo_u  = rs_i / rt_safe_u;
   assign rem_u  = rs_i % rt_safe_u;

   always_comb begin
      hi_o = 32'd0;
      lo_o = 32'd0;
      case (op_i)
         MD_OP_MULT:  {hi_o, lo_o} = prod_s;
         MD_OP_MULTU: {hi_o, lo_o} = prod_u;
         MD_OP_DIV: begin
            if (div_zero)     {hi_o, lo_o} = {rs_i, 32'hFFFF_FFFF};
            else if (div_ovf) {hi_o, lo_o} = {32'd0, 32'h8000_0000};
            else              {hi_o, lo_o} = {rem_s, quo_s};
         end
         MD_OP_DIVU: begin
            if (div_zero) {hi_o, lo_o} = {rs_i, 32'hFFFF_FFFF};
            else          {hi_o, lo_o} = {rem_u, quo_u};
         end
         default: {hi_o, lo_o} = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: holds HI/LO, models fixed MD latency
// with a busy FSM and raises the D-stage stall for MD instructions.
`timescale 1ns/1ps
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        iclk,
   input  logic        irst_n,
   input  logic        ivalid,
   input  logic [2:0]  iop,
   input  logic [31:0] irs,
   input  logic [31:0] irt,
   input  logic        iuse_md,
   output logic [31:0] oHI,
   output logic [31:0] oLO,
   output logic        obusy,
   output logic        ostall,
   output logic [1:0]  ostate
);

   localparam int CNT_W = cnt_width(max_int(MULT_CYCLES, DIV_CYCLES));

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic [31:0]      res_hi, res_lo;
   logic             idle, start, mt_hi, mt_lo, commit;

   md_arith u_arith (
      .op_i (iop),
      .rs_i (irs),
      .rt_i (irt),
      .hi_o (res_hi),
      .lo_o (res_lo)
   );

   assign idle   = (state_q == MD_ST_IDLE);
   assign start  = ivalid && idle && is_long_op(iop);
   assign mt_hi  = ivalid && idle && (iop == MD_OP_MTHI);
   assign mt_lo  = ivalid && idle && (iop == MD_OP_MTLO);
   assign commit = !idle && (cnt_q == '0);

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q   <= MD_ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MD_ST_IDLE: begin
            if (start) begin
               if ((iop == MD_OP_MULT) || (iop == MD_OP_MULTU)) begin
                  state_d = MD_ST_MUL;
                  cnt_d   = CNT_W'(MULT_CYCLES - 1);
               end else begin
                  state_d = MD_ST_DIV;
                  cnt_d   = CNT_W'(DIV_CYCLES - 1);
               end
            end
         end
         MD_ST_MUL, MD_ST_DIV: begin
            if (cnt_q == '0) state_d = MD_ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: begin
            state_d = MD_ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Result is computed in the issue cycle and parked until the latency expires.
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      if (start) begin
         pend_hi_d = res_hi;
         pend_lo_d = res_lo;
      end
      if (commit) begin
         hi_d = pend_hi_q;
         lo_d = pend_lo_q;
      end
      if (mt_hi) hi_d = irs;
      if (mt_lo) lo_d = irs;
   end

   assign oHI    = hi_q;
   assign oLO    = lo_q;
   assign obusy  = !idle;
   assign ostall = iuse_md && (obusy || start);
   assign ostate = state_q;

`ifndef SYNTHESIS
   // An MD op reaching E while busy means the hazard unit let it through.
   always @(posedge iclk) begin
      if (irst_n) begin
         assert (!(ivalid && !idle && is_md_op(iop)))
            else $warning("md_sequencer: MD op %0d issued while unit busy", iop);
      end
   end
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus random
// multiply/divide traffic, results tracked through an expected queue.
`timescale 1ns/1ps
module tb_md_sequencer;
   import md_sequencer_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        iclk = 1'b0;
   logic        irst_n = 1'b0;
   logic        ivalid = 1'b0;
   logic [2:0]  iop = MD_OP_NONE;
   logic [31:0] irs = 32'd0;
   logic [31:0] irt = 32'd0;
   logic        iuse_md = 1'b0;
   logic [31:0] oHI, oLO;
   logic        obusy, ostall;
   logic [1:0]  ostate;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .iclk    (iclk),
      .irst_n  (irst_n),
      .ivalid  (ivalid),
      .iop     (iop),
      .irs     (irs),
      .irt     (irt),
      .iuse_md (iuse_md),
      .oHI     (oHI),
      .oLO     (oLO),
      .obusy   (obusy),
      .ostall  (ostall),
      .ostate  (ostate)
   );

   always #5 iclk = ~iclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   task automatic idle_inputs();
      ivalid = 1'b0;
      iop    = MD_OP_NONE;
      irs    = 32'd0;
      irt    = 32'd0;
   endtask

   // Reference model via magnitudes and sign fix-up.
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      longint      pa;
      ref_md = 64'd0;
      case (op)
         MD_OP_MULT: begin
            pa = longint'($signed(a)) * longint'($signed(b));
            ref_md = pa;
         end
         MD_OP_MULTU: ref_md = {32'd0, a} * {32'd0, b};
         MD_OP_DIV: begin
            if (b == 32'd0) ref_md = {a, 32'hFFFF_FFFF};
            else begin
               ma = a[31] ? -a : a;
               mb = b[31] ? -b : b;
               q  = ma / mb;
               r  = ma % mb;
               if (a[31] ^ b[31]) q = -q;
               if (a[31]) r = -r;
               ref_md = {r, q};
            end
         end
         MD_OP_DIVU: begin
            if (b == 32'd0) ref_md = {a, 32'hFFFF_FFFF};
            else            ref_md = {a % b, a / b};
         end
         default: ref_md = 64'd0;
      endcase
   endfunction

   // Issues in the current cycle t, checks busy/hold for t+1..t+n and result at t+n+1.
   task automatic run_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int n, input logic [63:0] exp_res, input string name);
      logic [63:0] exp_v;
      ivalid = 1'b1; iop = op; irs = rs; irt = rt;
      exp_q.push_back(exp_res);
      #1;
      checks++;
      if (obusy !== 1'b0) begin
         errors++; $display("FAIL %s busy_at_issue: got %b want 0", name, obusy);
      end
      for (int k = 1; k <= n; k++) begin
         step();
         idle_inputs();
         #1;
         checks++;
         if (obusy !== 1'b1) begin
            errors++; $display("FAIL %s busy_cycle%0d: got %b want 1", name, k, obusy);
         end
         checks++;
         if ({oHI, oLO} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL %s hold_cycle%0d: got %h want %h", name, k, {oHI, oLO}, {m_hi, m_lo});
         end
      end
      step();
      checks++;
      if (obusy !== 1'b0) begin
         errors++; $display("FAIL %s busy_after: got %b want 0", name, obusy);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL %s scoreboard: got empty queue want entry", name);
      end else begin
         exp_v = exp_q.pop_front();
         if ({oHI, oLO} !== exp_v) begin
            errors++; $display("FAIL %s result: got %h want %h", name, {oHI, oLO}, exp_v);
         end
         m_hi = exp_v[63:32];
         m_lo = exp_v[31:0];
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      iuse_md = 1'b1;
      #3;
      checks++;
      if ({oHI, oLO} !== 64'd0) begin
         errors++; $display("FAIL reset_hilo: got %h want 0", {oHI, oLO});
      end
      checks++;
      if ({obusy, ostall, ostate} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0000", {obusy, ostall, ostate});
      end
      iuse_md = 1'b0;
      @(negedge iclk);
      irst_n = 1'b1;
      step();
   endtask

   task automatic test_mult();
      run_md(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, MULT_N, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, "mult_neg");
   endtask

   task automatic test_div_stall();
      int n;
      logic [63:0] exp_v;
      ivalid = 1'b1; iop = MD_OP_DIVU; irs = 32'd100; irt = 32'd7; iuse_md = 1'b1;
      exp_q.push_back({32'd2, 32'd14});
      #1;
      n = 0;
      while (ostall === 1'b1 && n < 40) begin
         n++;
         step();
         idle_inputs();
         #1;
      end
      checks++;
      if (n != DIV_N + 1) begin
         errors++; $display("FAIL divu_stall_len: got %0d want %0d", n, DIV_N + 1);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if ({oHI, oLO} !== exp_v) begin
         errors++; $display("FAIL divu_result: got %h want %h", {oHI, oLO}, exp_v);
      end
      m_hi = exp_v[63:32];
      m_lo = exp_v[31:0];
      iuse_md = 1'b0;
      run_md(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg");
   endtask

   task automatic test_div_special();
      run_md(MD_OP_DIV, 32'd5, 32'd0, DIV_N, {32'd5, 32'hFFFF_FFFF}, "div_by_zero");
      run_md(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, {32'd0, 32'h8000_0000}, "div_ovf");
      run_md(MD_OP_DIVU, 32'd9, 32'd0, DIV_N, {32'd9, 32'hFFFF_FFFF}, "divu_by_zero");
   endtask

   task automatic test_mt();
      ivalid = 1'b1; iop = MD_OP_MTLO; irs = 32'h1234; iuse_md = 1'b1;
      #1;
      checks++;
      if ({ostall, obusy} !== 2'b00) begin
         errors++; $display("FAIL mtlo_no_stall: got %b want 00", {ostall, obusy});
      end
      step();
      idle_inputs();
      iuse_md = 1'b0;
      checks++;
      if ({oHI, oLO, obusy} !== {m_hi, 32'h1234, 1'b0}) begin
         errors++; $display("FAIL mtlo_land: got %h/%h/%b want %h/00001234/0", oHI, oLO, obusy, m_hi);
      end
      m_lo = 32'h1234;
      ivalid = 1'b1; iop = MD_OP_MTHI; irs = 32'hA5A5_0001;
      step();
      iop = MD_OP_MTLO; irs = 32'h5A5A_0002;
      step();
      idle_inputs();
      checks++;
      if ({oHI, oLO} !== {32'hA5A5_0001, 32'h5A5A_0002}) begin
         errors++; $display("FAIL mt_back_to_back: got %h want a5a500015a5a0002", {oHI, oLO});
      end
      m_hi = 32'hA5A5_0001;
      m_lo = 32'h5A5A_0002;
   endtask

   task automatic test_reset_mid();
      ivalid = 1'b1; iop = MD_OP_MULTU; irs = 32'hFFFF_FFFF; irt = 32'hFFFF_FFFF;
      step();
      idle_inputs();
      step();
      step();
      irst_n = 1'b0;
      #1;
      checks++;
      if ({obusy, ostate, oHI, oLO} !== 67'd0) begin
         errors++; $display("FAIL reset_mid: got busy=%b st=%0d %h want all zero", obusy, ostate, {oHI, oLO});
      end
      step();
      irst_n = 1'b1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      step();
      checks++;
      if ({obusy, oHI, oLO} !== 65'd0) begin
         errors++; $display("FAIL reset_mid_no_commit: got busy=%b %h want zero", obusy, {oHI, oLO});
      end
      run_md(MD_OP_MULT, 32'd7, 32'hFFFF_FFFA, MULT_N, {32'hFFFF_FFFF, 32'hFFFF_FFD6}, "mult_after_reset");
   endtask

   task automatic test_ignored();
      ivalid = 1'b0; iop = MD_OP_MULT; irs = 32'd3; irt = 32'd4; iuse_md = 1'b1;
      #1;
      checks++;
      if (ostall !== 1'b0) begin
         errors++; $display("FAIL bubble_stall: got %b want 0", ostall);
      end
      step();
      ivalid = 1'b1; iop = 3'd7;
      step();
      idle_inputs();
      iuse_md = 1'b0;
      checks++;
      if ({obusy, oHI, oLO} !== {1'b0, m_hi, m_lo}) begin
         errors++; $display("FAIL bubble_no_effect: got %b/%h want 0/%h", obusy, {oHI, oLO}, {m_hi, m_lo});
      end
      ivalid = 1'b1; iop = MD_OP_MULT; irs = 32'd6; irt = 32'd7;
      step();
      idle_inputs();
      step();
      ivalid = 1'b1; iop = MD_OP_MTHI; irs = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (ostate !== 2'd1) begin
         errors++; $display("FAIL busy_state: got %0d want 1", ostate);
      end
      step();
      idle_inputs();
      step();
      step();
      step();
      checks++;
      if ({obusy, oHI, oLO} !== {1'b0, 32'd0, 32'd42}) begin
         errors++; $display("FAIL mthi_while_busy: got %b/%h want 0/000000000000002a", obusy, {oHI, oLO});
      end
      m_hi = 32'd0;
      m_lo = 32'd42;
   endtask

   task automatic test_back_to_back();
      run_md(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, MULT_N, {32'd1, 32'hFFFF_FFFE}, "b2b_multu");
      run_md(MD_OP_DIVU, 32'hFFFF_FFFF, 32'd10, DIV_N, {32'd5, 32'h1999_9999}, "b2b_divu");
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(1, 4));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
         run_md(op, a, b, (op <= MD_OP_MULTU) ? MULT_N : DIV_N, ref_md(op, a, b), "random");
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div_stall();
      test_div_special();
      test_mt();
      test_reset_mid();
      test_ignored();
      test_back_to_back();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
